// File: rtl/uart_pkg.sv
// Frame format and receiver state encoding shared by the UART transmitter and receiver.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Byte-out side of the UART receiver: received byte, strobes and busy flag.
interface uart_rx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] data;
    logic                      valid;
    logic                      frame_err;
    logic                      busy;

    modport master (output data, output valid, output frame_err, output busy);
    modport slave  (input  data, input  valid, input  frame_err, input  busy);
endinterface

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous rx line; resets to the idle (high) level.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_rx,
    output logic o_rx_s
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
        end
    end

    assign o_rx_s = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a cycle counter, start/stop validation,
// one-cycle valid / frame_err strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rx,
    uart_rx_if.master rx_if
);

    localparam logic [13:0] HALF_M1 = 14'(CLKS_PER_BIT / 2 - 1);
    localparam logic [13:0] FULL_M1 = 14'(CLKS_PER_BIT - 1);

    rx_state_t                 r_state, w_state_nxt;
    logic [13:0]               r_cnt, w_cnt_nxt;
    logic [2:0]                r_bit_idx, w_bit_idx_nxt;
    logic [UART_DATA_BITS-1:0] r_shreg, w_shreg_nxt;
    logic [UART_DATA_BITS-1:0] r_data, w_data_nxt;
    logic                      r_valid, w_valid_nxt;
    logic                      r_frame_err, w_frame_err_nxt;
    logic                      w_rx_s;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_rx   (rx),
        .o_rx_s (w_rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shreg     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_shreg     <= w_shreg_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_bit_idx_nxt   = r_bit_idx;
        w_shreg_nxt     = r_shreg;
        w_data_nxt      = r_data;
        w_valid_nxt     = 1'b0;
        w_frame_err_nxt = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = START;
                    w_cnt_nxt   = '0;
                end
            end
            // Half a bit after the falling edge: a high line here was only a glitch.
            START: begin
                if (r_cnt == HALF_M1) begin
                    w_cnt_nxt = '0;
                    if (!w_rx_s) begin
                        w_state_nxt   = DATA;
                        w_bit_idx_nxt = '0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 14'd1;
                end
            end
            DATA: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt_nxt     = '0;
                    w_shreg_nxt   = {w_rx_s, r_shreg[UART_DATA_BITS-1:1]};
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = STOP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 14'd1;
                end
            end
            STOP: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt_nxt = '0;
                    if (w_rx_s) begin
                        w_data_nxt  = r_shreg;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = BREAK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 14'd1;
                end
            end
            // A held-low line must not be mistaken for a stream of start bits.
            BREAK: begin
                if (w_rx_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign rx_if.data      = r_data;
    assign rx_if.valid     = r_valid;
    assign rx_if.frame_err = r_frame_err;
    // The strobe cycle follows the return to IDLE, so it is folded into busy explicitly.
    assign rx_if.busy      = (r_state != IDLE) || r_valid || r_frame_err;

endmodule
